// File: rtl/pe_bitplane_feeder_if.sv
// Stream and PE-side signal bundle for the bit-plane feeder.
// master = upstream/PE environment, slave = the feeder itself.
interface pe_bitplane_feeder_if #(
    parameter int peDataInWidth = 1024,
    parameter int actBits       = 4
);
    localparam int IdxW = $clog2(actBits);

    logic                               s_valid;
    logic                               s_ready;
    logic [peDataInWidth*actBits-1:0]   s_data;
    logic                               hold;
    logic                               pe_valid;
    logic [peDataInWidth-1:0]           pe_data;
    logic [IdxW-1:0]                    pe_plane_idx;
    logic                               pe_last;
    logic                               res_valid;
    logic [IdxW-1:0]                    res_plane_idx;
    logic                               res_last;
    logic                               busy;

    modport master (
        output s_valid, s_data, hold,
        input  s_ready, pe_valid, pe_data, pe_plane_idx, pe_last,
               res_valid, res_plane_idx, res_last, busy
    );

    modport slave (
        input  s_valid, s_data, hold,
        output s_ready, pe_valid, pe_data, pe_plane_idx, pe_last,
               res_valid, res_plane_idx, res_last, busy
    );
endinterface

// File: rtl/pe_bitplane_feeder.sv
// Purpose: serialises activation vectors into LSB-first bit-planes for a PE and tags PE results.
// Latency: plane 0 on pe_data 1 cycle after accept; result tags trail pe_valid by peLatency cycles.
// Backpressure: hold freezes the current plane and blocks the next accept; s_ready only in IDLE or on the last unheld plane.
module pe_bitplane_feeder #(
    parameter int nSaRows       = 256,
    parameter int nRowSaInPE    = 4,
    parameter int actBits       = 4,
    parameter int peLatency     = 2,
    parameter int peDataInWidth = nSaRows * nRowSaInPE
) (
    input  logic                  clk,
    input  logic                  nrst,
    pe_bitplane_feeder_if.slave   bus
);
    localparam int              IdxW    = $clog2(actBits);
    localparam int              BufW    = peDataInWidth * actBits;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(actBits - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]               state;
    logic [IdxW-1:0]          cnt;
    logic [BufW-1:0]          buffer;
    logic                     last_plane;
    logic                     pe_valid_c;
    logic                     s_ready_c;
    logic                     accept;
    logic [peDataInWidth-1:0] plane_c;

    logic [peLatency-1:0]     pipe_vld;
    logic [IdxW-1:0]          pipe_idx  [peLatency];
    logic [peLatency-1:0]     pipe_last;

    assign last_plane = (cnt == LastIdx);
    assign pe_valid_c = (state == STREAM) && !bus.hold;
    assign s_ready_c  = (state == IDLE) || ((state == STREAM) && last_plane && !bus.hold);
    assign accept     = bus.s_valid && s_ready_c;

    // Plane cnt gathers bit cnt of every element; shown even when idle so pe_data never glitches.
    always_comb begin
        plane_c = '0;
        for (int i = 0; i < peDataInWidth; i++) begin
            plane_c[i] = buffer[i*actBits + int'(cnt)];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            buffer <= '0;
        end else if (accept) begin
            state  <= STREAM;
            cnt    <= '0;
            buffer <= bus.s_data;
        end else if (pe_valid_c) begin
            if (last_plane) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Tag pipeline free-runs through hold so tags stay aligned with the PE's fixed latency.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
            for (int k = 0; k < peLatency; k++) begin
                pipe_idx[k] <= '0;
            end
        end else begin
            pipe_vld[0]  <= pe_valid_c;
            pipe_idx[0]  <= cnt;
            pipe_last[0] <= last_plane;
            for (int k = 1; k < peLatency; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_idx[k]  <= pipe_idx[k-1];
                pipe_last[k] <= pipe_last[k-1];
            end
        end
    end

    assign bus.s_ready       = s_ready_c;
    assign bus.pe_valid      = pe_valid_c;
    assign bus.pe_data       = plane_c;
    assign bus.pe_plane_idx  = cnt;
    assign bus.pe_last       = last_plane;
    assign bus.res_valid     = pipe_vld[peLatency-1];
    assign bus.res_plane_idx = pipe_idx[peLatency-1];
    assign bus.res_last      = pipe_last[peLatency-1];
    assign bus.busy          = (state == STREAM) || (|pipe_vld);
endmodule

// File: tb/tb_pe_bitplane_feeder.sv
// Cycle-table bench for pe_bitplane_feeder (width 8, 4 planes, PE latency 2) plus a mid-stream reset sequence.
module tb_pe_bitplane_feeder;
    logic clk;
    logic nrst;
    int   total;
    int   bad;

    pe_bitplane_feeder_if #(.peDataInWidth(8), .actBits(4)) bus ();

    pe_bitplane_feeder #(
        .nSaRows(4), .nRowSaInPE(2), .actBits(4), .peLatency(2)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        hold;
        logic        rdy;
        logic        pv;
        logic [7:0]  pd;
        logic [1:0]  pi;
        logic        pl;
        logic        rv;
        logic [1:0]  ri;
        logic        rl;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sv, input logic [31:0] sd, input logic hold,
                                input logic rdy, input logic pv, input logic [7:0] pd,
                                input logic [1:0] pi, input logic pl, input logic rv,
                                input logic [1:0] ri, input logic rl, input logic busy);
        vec_t v;
        v.sv = sv; v.sd = sd; v.hold = hold; v.rdy = rdy; v.pv = pv; v.pd = pd;
        v.pi = pi; v.pl = pl; v.rv = rv; v.ri = ri; v.rl = rl; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    localparam logic [31:0] V_A = 32'hAAAA_AAAA;
    localparam logic [31:0] V_F = 32'hFFFF_FFFF;
    localparam logic [31:0] V_Z = 32'h0000_0000;
    localparam logic [31:0] V_M = 32'hFEDC_BA98;
    localparam logic [31:0] V_1 = 32'h1111_1111;

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.hold    = 1'b0;

        //          sv  sd  hld  rdy pv  pd     pi pl  rv ri rl busy
        // single vector of 4'b1010
        tbl.push_back(mk(1, V_A, 0,  1, 0, 8'h00, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, V_A, 0,  0, 1, 8'h00, 0, 0,  0, 0, 0, 1));
        tbl.push_back(mk(0, V_A, 0,  0, 1, 8'hFF, 1, 0,  0, 0, 0, 1));
        tbl.push_back(mk(0, V_A, 0,  0, 1, 8'h00, 2, 0,  1, 0, 0, 1));
        tbl.push_back(mk(0, V_A, 0,  1, 1, 8'hFF, 3, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, V_A, 0,  1, 0, 8'h00, 0, 0,  1, 2, 0, 1));
        tbl.push_back(mk(0, V_A, 0,  1, 0, 8'h00, 0, 0,  1, 3, 1, 1));
        tbl.push_back(mk(0, V_A, 0,  1, 0, 8'h00, 0, 0,  0, 0, 0, 0));
        // back-to-back A (all F) then B (all 0)
        tbl.push_back(mk(1, V_F, 0,  1, 0, 8'h00, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, V_F, 0,  0, 1, 8'hFF, 0, 0,  0, 0, 0, 1));
        tbl.push_back(mk(1, V_F, 0,  0, 1, 8'hFF, 1, 0,  0, 0, 0, 1));
        tbl.push_back(mk(1, V_F, 0,  0, 1, 8'hFF, 2, 0,  1, 0, 0, 1));
        tbl.push_back(mk(1, V_Z, 0,  1, 1, 8'hFF, 3, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, V_Z, 0,  0, 1, 8'h00, 0, 0,  1, 2, 0, 1));
        tbl.push_back(mk(0, V_Z, 0,  0, 1, 8'h00, 1, 0,  1, 3, 1, 1));
        tbl.push_back(mk(0, V_Z, 0,  0, 1, 8'h00, 2, 0,  1, 0, 0, 1));
        tbl.push_back(mk(0, V_Z, 0,  1, 1, 8'h00, 3, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, V_Z, 0,  1, 0, 8'h00, 0, 0,  1, 2, 0, 1));
        tbl.push_back(mk(0, V_Z, 0,  1, 0, 8'h00, 0, 0,  1, 3, 1, 1));
        tbl.push_back(mk(0, V_Z, 0,  1, 0, 8'h00, 0, 0,  0, 0, 0, 0));
        // elements 8..15: planes AA, CC, F0, FF; 3-cycle hold on plane 1, 2-cycle hold on plane 3
        tbl.push_back(mk(1, V_M, 0,  1, 0, 8'h00, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, V_M, 0,  0, 1, 8'hAA, 0, 0,  0, 0, 0, 1));
        tbl.push_back(mk(0, V_M, 1,  0, 0, 8'hCC, 1, 0,  0, 0, 0, 1));
        tbl.push_back(mk(0, V_M, 1,  0, 0, 8'hCC, 1, 0,  1, 0, 0, 1));
        tbl.push_back(mk(0, V_M, 1,  0, 0, 8'hCC, 1, 0,  0, 1, 0, 1));
        tbl.push_back(mk(0, V_M, 0,  0, 1, 8'hCC, 1, 0,  0, 1, 0, 1));
        tbl.push_back(mk(0, V_M, 0,  0, 1, 8'hF0, 2, 0,  0, 1, 0, 1));
        tbl.push_back(mk(1, V_1, 1,  0, 0, 8'hFF, 3, 1,  1, 1, 0, 1));
        tbl.push_back(mk(1, V_1, 1,  0, 0, 8'hFF, 3, 1,  1, 2, 0, 1));
        tbl.push_back(mk(1, V_1, 0,  1, 1, 8'hFF, 3, 1,  0, 3, 1, 1));
        tbl.push_back(mk(0, V_1, 0,  0, 1, 8'hFF, 0, 0,  0, 3, 1, 1));
        tbl.push_back(mk(0, V_1, 0,  0, 1, 8'h00, 1, 0,  1, 3, 1, 1));
        tbl.push_back(mk(0, V_1, 0,  0, 1, 8'h00, 2, 0,  1, 0, 0, 1));
        tbl.push_back(mk(0, V_1, 0,  1, 1, 8'h00, 3, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, V_1, 0,  1, 0, 8'hFF, 0, 0,  1, 2, 0, 1));
        tbl.push_back(mk(0, V_1, 0,  1, 0, 8'hFF, 0, 0,  1, 3, 1, 1));
        // hold while idle leaves s_ready up
        tbl.push_back(mk(0, V_1, 1,  1, 0, 8'hFF, 0, 0,  0, 0, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready",  32'(bus.s_ready),   32'd1);
        chk("rst_pe_valid", 32'(bus.pe_valid),  32'd0);
        chk("rst_pe_data",  32'(bus.pe_data),   32'h00);
        chk("rst_pe_idx",   32'(bus.pe_plane_idx), 32'd0);
        chk("rst_pe_last",  32'(bus.pe_last),   32'd0);
        chk("rst_res_valid",32'(bus.res_valid), 32'd0);
        chk("rst_busy",     32'(bus.busy),      32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;

        for (int c = 0; c < tbl.size(); c++) begin
            bus.s_valid = tbl[c].sv;
            bus.s_data  = tbl[c].sd;
            bus.hold    = tbl[c].hold;
            @(negedge clk);
            chk($sformatf("c%0d_s_ready", c),   32'(bus.s_ready),       32'(tbl[c].rdy));
            chk($sformatf("c%0d_pe_valid", c),  32'(bus.pe_valid),      32'(tbl[c].pv));
            chk($sformatf("c%0d_pe_data", c),   32'(bus.pe_data),       32'(tbl[c].pd));
            chk($sformatf("c%0d_pe_idx", c),    32'(bus.pe_plane_idx),  32'(tbl[c].pi));
            chk($sformatf("c%0d_pe_last", c),   32'(bus.pe_last),       32'(tbl[c].pl));
            chk($sformatf("c%0d_res_valid", c), 32'(bus.res_valid),     32'(tbl[c].rv));
            chk($sformatf("c%0d_res_idx", c),   32'(bus.res_plane_idx), 32'(tbl[c].ri));
            chk($sformatf("c%0d_res_last", c),  32'(bus.res_last),      32'(tbl[c].rl));
            chk($sformatf("c%0d_busy", c),      32'(bus.busy),          32'(tbl[c].busy));
            @(posedge clk);
            #1;
        end

        // reset while plane 2 is on pe_data and result tags are in flight
        bus.s_valid = 1'b1;
        bus.s_data  = V_M;
        bus.hold    = 1'b0;
        @(negedge clk);
        chk("mr_accept_rdy", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mr_pre_idx",   32'(bus.pe_plane_idx), 32'd2);
        chk("mr_pre_data",  32'(bus.pe_data),      32'hF0);
        chk("mr_pre_rv",    32'(bus.res_valid),    32'd1);
        #1 nrst = 1'b0;
        #1;
        chk("mr_pe_valid",  32'(bus.pe_valid),     32'd0);
        chk("mr_res_valid", 32'(bus.res_valid),    32'd0);
        chk("mr_busy",      32'(bus.busy),         32'd0);
        chk("mr_s_ready",   32'(bus.s_ready),      32'd1);
        chk("mr_pe_data",   32'(bus.pe_data),      32'h00);
        chk("mr_pe_idx",    32'(bus.pe_plane_idx), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = V_1;
        @(negedge clk);
        chk("post_s_ready", 32'(bus.s_ready),  32'd1);
        chk("post_busy",    32'(bus.busy),     32'd0);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        @(negedge clk);
        chk("post_pe_valid", 32'(bus.pe_valid),     32'd1);
        chk("post_pe_idx",   32'(bus.pe_plane_idx), 32'd0);
        chk("post_pe_data",  32'(bus.pe_data),      32'hFF);
        chk("post_res_valid",32'(bus.res_valid),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
